// File: rtl/button_debouncer_pkg.sv
// ---------------------------------------------------------------------------
// button_debouncer_pkg
//   Shared definitions for the button debouncer:
//     - stable_cycles(freq, ms): clock cycles an input must hold before the
//       filtered output follows it (64-bit math, clamped to at least 1).
//     - cnt_width(n): bits needed for a counter that reaches n-1 (sized n+1).
//     - chan_state_e: per-channel filter state.
// ---------------------------------------------------------------------------
package button_debouncer_pkg;

    // STABLE: synchronised input equals the filtered output.
    // SETTLING: they differ and the stability timer is running.
    typedef enum logic {
        STABLE   = 1'b0,
        SETTLING = 1'b1
    } chan_state_e;

    function automatic int unsigned stable_cycles(input longint unsigned freq,
                                                  input longint unsigned ms);
        longint unsigned n;
        n = (freq / 64'd1000) * ms;
        if (n == 64'd0) begin
            n = 64'd1;
        end
        return n[31:0];
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n + 32'd1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
//   One debounced input: 2-flop synchroniser, stability counter, registered
//   output and optional one-cycle edge strobes.
//   Optional feature macro: BUTTON_DEBOUNCER_EDGE_PULSE_EN builds the strobe
//   registers; otherwise rise_o/fall_o are constant 0.
// Ports:
//   clock       - sole clock
//   reset       - synchronous, active-high
//   raw_i       - asynchronous, bouncing pin level
//   debounced_o - filtered level (registered)
//   rise_o      - one-cycle strobe when debounced_o goes 0->1
//   fall_o      - one-cycle strobe when debounced_o goes 1->0
// Handshake: none; a level input and level/strobe outputs, no valid/ready.
// ---------------------------------------------------------------------------
module debounce_channel
    import button_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 1,
    parameter logic        INIT          = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic raw_i,
    output logic debounced_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned      CW   = cnt_width(STABLE_CYCLES);
    localparam logic [CW-1:0]    LAST = CW'(STABLE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q, deb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    chan_state_e   state;
    logic          expire;

    // Synchroniser flops reset to INIT so the filter sees no false
    // transition in the cycles right after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= INIT;
            sync2_q <= INIT;
            deb_q   <= INIT;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    // The state is fully determined by comparing the synchronised input
    // with the filtered output; any return to equality clears the counter,
    // so glitches shorter than STABLE_CYCLES never reach the output.
    always_comb begin
        state  = (sync2_q != deb_q) ? SETTLING : STABLE;
        expire = (state == SETTLING) && (cnt_q == LAST);
        deb_d  = deb_q;
        cnt_d  = '0;
        if (state == SETTLING) begin
            if (expire) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign debounced_o = deb_q;

`ifdef BUTTON_DEBOUNCER_EDGE_PULSE_EN
    logic rise_q;
    logic fall_q;

    // Strobes are set on the same edge that updates deb_q, so they are
    // high exactly in the first cycle the new level is visible.
    always_ff @(posedge clock) begin
        if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= expire & sync2_q;
            fall_q <= expire & ~sync2_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;
`else
    assign rise_o = 1'b0;
    assign fall_o = 1'b0;
`endif

endmodule

// File: rtl/button_debouncer.sv
// ---------------------------------------------------------------------------
// button_debouncer
//   Multi-channel input conditioner for push-buttons, switches and external
//   reset pins. Each channel is synchronised and then filtered so its output
//   changes only after the input has been stable for DEBOUNCE_MS.
//   Optional feature macro: BUTTON_DEBOUNCER_EDGE_PULSE_EN enables the
//   rise_pulse/fall_pulse strobes; when undefined they read constant 0 and
//   the debounced behaviour is unchanged.
// Ports:
//   clock      - sole clock (CLOCK_FREQUENCY Hz)
//   reset      - synchronous, active-high
//   raw_input  - WIDTH asynchronous pin levels
//   debounced  - WIDTH filtered levels (registered)
//   rise_pulse - WIDTH one-cycle strobes on debounced 0->1
//   fall_pulse - WIDTH one-cycle strobes on debounced 1->0
// ---------------------------------------------------------------------------
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int unsigned      WIDTH           = 3,
    parameter int unsigned      CLOCK_FREQUENCY = 50000000,
    parameter int unsigned      DEBOUNCE_MS     = 10,
    parameter logic [WIDTH-1:0] INIT_VALUE      = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] raw_input,
    output logic [WIDTH-1:0] debounced,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    localparam int unsigned STABLE_CYCLES =
        stable_cycles(64'(CLOCK_FREQUENCY), 64'(DEBOUNCE_MS));

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .INIT          (INIT_VALUE[i])
        ) u_chan (
            .clock       (clock),
            .reset       (reset),
            .raw_i       (raw_input[i]),
            .debounced_o (debounced[i]),
            .rise_o      (rise_pulse[i]),
            .fall_o      (fall_pulse[i])
        );
    end

endmodule
